// File: rtl/phase_pkg.sv
// Shared types and helpers for the phase sequencer family.
// The legacy two-phase CYCLES enum is kept alongside the N-phase additions.
package phase_pkg;

  typedef enum logic {
    CYC_PHI1,
    CYC_PHI2
  } cycles_t;

  typedef enum logic [1:0] {
    SEQ_RUN,
    SEQ_STEP,
    SEQ_HOLD,
    SEQ_RSVD
  } seq_mode_t;

  localparam int unsigned MAX_PHASES = 16;
  localparam int unsigned MAX_IDX_W  = 4;

  function automatic logic [MAX_PHASES-1:0] onehot_of(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_PHASES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/phase_dwell_counter.sv
// Per-phase dwell counter with clear/increment/hold and a >= terminal compare.
module phase_dwell_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             term_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // >= so that shrinking the limit mid-phase terminates instead of wrapping
  assign term_c = (cnt_q >= limit);

endmodule

// File: rtl/phase_sequencer.sv
// N-phase rotating sequencer with programmable per-phase dwell and
// run / single-step / hold modes; all outputs registered.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned CYC_W      = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          EN,
  input  logic [1:0]                    MODE,
  input  logic                          STEP_REQ,
  input  logic [NUM_PHASES*CNT_W-1:0]   DWELL,
  output logic [$clog2(NUM_PHASES)-1:0] PHASE_IDX,
  output logic [NUM_PHASES-1:0]         PHASE_OH,
  output logic                          WRAP,
  output logic [CYC_W-1:0]              CYCLE_CNT
);

  localparam int unsigned IDX_W = $clog2(NUM_PHASES);

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_PHASES-1:0] oh_q, oh_d;
  logic                  wrap_q, wrap_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic                  step_prev_q, step_prev_d;

  logic                  cnt_clr_c;
  logic                  cnt_inc_c;
  logic                  cnt_term_c;
  logic                  advance_c;
  logic [CNT_W-1:0]      dwell_lim_c;
  logic [MAX_PHASES-1:0] oh_full_c;
  seq_mode_t             mode_c;

  assign mode_c      = seq_mode_t'(MODE);
  assign dwell_lim_c = DWELL[int'(idx_q)*CNT_W +: CNT_W];

  phase_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk    (CLK),
    .rst    (RST),
    .clr    (cnt_clr_c),
    .inc    (cnt_inc_c),
    .limit  (dwell_lim_c),
    .term_c (cnt_term_c)
  );

  // Mode decode, advance and wrap bookkeeping
  always_comb begin
    idx_d       = idx_q;
    wrap_d      = 1'b0;
    cyc_d       = cyc_q;
    step_prev_d = step_prev_q;
    advance_c   = 1'b0;
    cnt_inc_c   = 1'b0;
    cnt_clr_c   = 1'b0;

    if (EN) begin
      step_prev_d = STEP_REQ;
      case (mode_c)
        SEQ_RUN: begin
          if (cnt_term_c) begin
            advance_c = 1'b1;
          end else begin
            cnt_inc_c = 1'b1;
          end
        end
        SEQ_STEP: begin
          advance_c = STEP_REQ & ~step_prev_q;
        end
        default: begin
        end
      endcase
    end

    if (advance_c) begin
      cnt_clr_c = 1'b1;
      if (idx_q == IDX_W'(NUM_PHASES - 1)) begin
        idx_d  = '0;
        wrap_d = 1'b1;
        cyc_d  = cyc_q + CYC_W'(1);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    oh_full_c = onehot_of(MAX_IDX_W'(idx_d));
    oh_d      = oh_full_c[NUM_PHASES-1:0];
  end

  generate
    if (NUM_PHASES < MAX_PHASES) begin : g_oh_unused
      logic unused_oh_c;
      assign unused_oh_c = ^oh_full_c[MAX_PHASES-1:NUM_PHASES];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q       <= '0;
      oh_q        <= NUM_PHASES'(1);
      wrap_q      <= 1'b0;
      cyc_q       <= '0;
      step_prev_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      oh_q        <= oh_d;
      wrap_q      <= wrap_d;
      cyc_q       <= cyc_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign PHASE_IDX = idx_q;
  assign PHASE_OH  = oh_q;
  assign WRAP      = wrap_q;
  assign CYCLE_CNT = cyc_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer (4 phases, plus a CYC_W=2 instance).
module tb_phase_sequencer;
  import phase_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned YW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en, step_req;
  logic [1:0]      mode;
  logic [NP*CW-1:0] dwell;
  logic [1:0]      idx;
  logic [NP-1:0]   oh;
  logic            wrap;
  logic [YW-1:0]   cyc;

  logic            rst2, en2, step2;
  logic [1:0]      mode2;
  logic [NP*CW-1:0] dwell2;
  logic [1:0]      idx2;
  logic [NP-1:0]   oh2;
  logic            wrap2;
  logic [1:0]      cyc2;

  int n_pass  = 0;
  int n_total = 0;

  phase_sequencer #(.NUM_PHASES(NP), .CNT_W(CW), .CYC_W(YW)) u_dut (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .STEP_REQ(step_req), .DWELL(dwell),
    .PHASE_IDX(idx), .PHASE_OH(oh), .WRAP(wrap), .CYCLE_CNT(cyc)
  );

  phase_sequencer #(.NUM_PHASES(NP), .CNT_W(CW), .CYC_W(2)) u_dut2 (
    .CLK(clk), .RST(rst2), .EN(en2), .MODE(mode2), .STEP_REQ(step2), .DWELL(dwell2),
    .PHASE_IDX(idx2), .PHASE_OH(oh2), .WRAP(wrap2), .CYCLE_CNT(cyc2)
  );

  always @(negedge clk) begin
    assert ($onehot(oh)) else $error("phase_oh not one-hot: %b", oh);
    assert ($onehot(oh2)) else $error("phase_oh (cyc_w=2) not one-hot: %b", oh2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [MAX_PHASES-1:0] eo;
    en = 1'b1; mode = 2'(SEQ_RUN); step_req = 1'b0; dwell = '0;
    rst = 1'b1;
    tick();
    tick();
    eo = onehot_of(4'(0));
    n_total++; if (idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", idx); else n_pass++;
    n_total++; if (oh !== eo[NP-1:0]) $display("FAIL reset_oh got %b want %b", oh, eo[NP-1:0]); else n_pass++;
    n_total++; if (wrap !== 1'b0) $display("FAIL reset_wrap got %b want 0", wrap); else n_pass++;
    n_total++; if (cyc !== 8'd0) $display("FAIL reset_cyc got %0d want 0", cyc); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_run_zero();
    int e_idx[8]  = '{1, 2, 3, 0, 1, 2, 3, 0};
    int e_wrap[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int e_cyc[8]  = '{0, 0, 0, 1, 1, 1, 1, 2};
    logic [MAX_PHASES-1:0] eo;
    dwell = '0; mode = 2'(SEQ_RUN); en = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      eo = onehot_of(4'(e_idx[k]));
      n_total++; if (idx !== 2'(e_idx[k])) $display("FAIL run0_idx[%0d] got %0d want %0d", k, idx, e_idx[k]); else n_pass++;
      n_total++; if (oh !== eo[NP-1:0]) $display("FAIL run0_oh[%0d] got %b want %b", k, oh, eo[NP-1:0]); else n_pass++;
      n_total++; if (wrap !== 1'(e_wrap[k])) $display("FAIL run0_wrap[%0d] got %b want %0d", k, wrap, e_wrap[k]); else n_pass++;
      n_total++; if (cyc !== 8'(e_cyc[k])) $display("FAIL run0_cyc[%0d] got %0d want %0d", k, cyc, e_cyc[k]); else n_pass++;
    end
  endtask

  // Phase lengths 2,3,1,4 -> positions 0-1:ph0, 2-4:ph1, 5:ph2, 6-9:ph3
  task automatic test_dwell();
    int p, e;
    dwell = {4'd3, 4'd0, 4'd2, 4'd1};
    mode = 2'(SEQ_RUN); en = 1'b1;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      tick();
      p = k % 10;
      e = (p < 2) ? 0 : (p < 5) ? 1 : (p < 6) ? 2 : 3;
      n_total++; if (idx !== 2'(e)) $display("FAIL dwell_idx[%0d] got %0d want %0d", k, idx, e); else n_pass++;
      n_total++; if (wrap !== (p == 0)) $display("FAIL dwell_wrap[%0d] got %b want %0d", k, wrap, (p == 0)); else n_pass++;
    end
    n_total++; if (cyc !== 8'd3) $display("FAIL dwell_cyc got %0d want 3", cyc); else n_pass++;
  endtask

  task automatic test_step();
    dwell = {4'd0, 4'd0, 4'd2, 4'd9};
    mode = 2'(SEQ_RUN); en = 1'b1; step_req = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    n_total++; if (idx !== 2'd0) $display("FAIL step_run5_idx got %0d want 0", idx); else n_pass++;
    mode = 2'(SEQ_STEP);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++; if (idx !== 2'd0) $display("FAIL step_noimplicit[%0d] got %0d want 0", k, idx); else n_pass++;
    end
    mode = 2'(SEQ_RUN);
    for (int k = 0; k < 4; k++) tick();
    n_total++; if (idx !== 2'd0) $display("FAIL step_resume_idx got %0d want 0", idx); else n_pass++;
    mode = 2'(SEQ_STEP); step_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++; if (idx !== 2'd1) $display("FAIL step_held[%0d] got %0d want 1", k, idx); else n_pass++;
    end
    step_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++; if (idx !== 2'd1) $display("FAIL step_low[%0d] got %0d want 1", k, idx); else n_pass++;
    end
    mode = 2'(SEQ_RUN);
    begin
      int e_idx[4] = '{1, 1, 2, 3};
      for (int k = 0; k < 4; k++) begin
        tick();
        n_total++; if (idx !== 2'(e_idx[k])) $display("FAIL step_then_run[%0d] got %0d want %0d", k, idx, e_idx[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_hold();
    dwell = {4'd0, 4'd0, 4'd0, 4'd3};
    mode = 2'(SEQ_RUN); en = 1'b1; step_req = 1'b0;
    do_reset();
    tick(); tick();
    mode = 2'(SEQ_HOLD);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (idx !== 2'd0 || wrap !== 1'b0) $display("FAIL hold[%0d] got idx %0d wrap %b want 0/0", k, idx, wrap); else n_pass++;
    end
    mode = 2'(SEQ_RSVD);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++; if (idx !== 2'd0) $display("FAIL rsvd[%0d] got %0d want 0", k, idx); else n_pass++;
    end
    mode = 2'(SEQ_RUN);
    tick();
    n_total++; if (idx !== 2'd0) $display("FAIL hold_retain_a got %0d want 0", idx); else n_pass++;
    tick();
    n_total++; if (idx !== 2'd1) $display("FAIL hold_retain_b got %0d want 1", idx); else n_pass++;
  endtask

  task automatic test_en_freeze();
    int e_idx[3] = '{1, 2, 2};
    int e_after[3] = '{2, 2, 3};
    dwell = {4'd0, 4'd3, 4'd0, 4'd0};
    mode = 2'(SEQ_RUN); en = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (idx !== 2'(e_idx[k])) $display("FAIL en_pre[%0d] got %0d want %0d", k, idx, e_idx[k]); else n_pass++;
    end
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      n_total++; if (idx !== 2'd2 || wrap !== 1'b0 || cyc !== 8'd0) $display("FAIL en_frozen[%0d] got idx %0d wrap %b cyc %0d want 2/0/0", k, idx, wrap, cyc); else n_pass++;
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (idx !== 2'(e_after[k])) $display("FAIL en_post[%0d] got %0d want %0d", k, idx, e_after[k]); else n_pass++;
    end
    tick();
    n_total++; if (idx !== 2'd0 || wrap !== 1'b1 || cyc !== 8'd1) $display("FAIL en_wrap got idx %0d wrap %b cyc %0d want 0/1/1", idx, wrap, cyc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int e_idx[5] = '{1, 2, 3, 3, 3};
    dwell = {4'd2, 4'd0, 4'd0, 4'd0};
    mode = 2'(SEQ_RUN); en = 1'b1; step_req = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++; if (idx !== 2'(e_idx[k])) $display("FAIL rmid_pre[%0d] got %0d want %0d", k, idx, e_idx[k]); else n_pass++;
    end
    rst = 1'b1;
    tick();
    n_total++; if (idx !== 2'd0 || wrap !== 1'b0 || cyc !== 8'd0 || oh !== 4'b0001) $display("FAIL rmid_reset got idx %0d wrap %b cyc %0d oh %b want 0/0/0/0001", idx, wrap, cyc, oh); else n_pass++;
    mode = 2'(SEQ_STEP); step_req = 1'b1;
    tick();
    n_total++; if (idx !== 2'd0) $display("FAIL rmid_step_in_reset got %0d want 0", idx); else n_pass++;
    rst = 1'b0; step_req = 1'b0; mode = 2'(SEQ_RUN);
  endtask

  task automatic test_step_edges();
    dwell = {NP{4'hF}};
    mode = 2'(SEQ_RUN); en = 1'b1; step_req = 1'b1;
    do_reset();
    tick(); tick();
    mode = 2'(SEQ_STEP);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++; if (idx !== 2'd0) $display("FAIL preheld[%0d] got %0d want 0", k, idx); else n_pass++;
    end
    step_req = 1'b0;
    tick();
    en = 1'b0; step_req = 1'b1;
    tick(); tick();
    n_total++; if (idx !== 2'd0) $display("FAIL straddle_frozen got %0d want 0", idx); else n_pass++;
    en = 1'b1;
    tick();
    n_total++; if (idx !== 2'd1) $display("FAIL straddle_edge got %0d want 1", idx); else n_pass++;
    tick();
    n_total++; if (idx !== 2'd1) $display("FAIL straddle_once got %0d want 1", idx); else n_pass++;
    step_req = 1'b0; mode = 2'(SEQ_RUN);
  endtask

  task automatic test_cyc_rollover();
    int e;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      e = (k / 4) % 4;
      n_total++; if (cyc2 !== 2'(e)) $display("FAIL cyc2[%0d] got %0d want %0d", k, cyc2, e); else n_pass++;
      n_total++; if (wrap2 !== (k % 4 == 0)) $display("FAIL wrap2[%0d] got %b want %0d", k, wrap2, (k % 4 == 0)); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'(SEQ_RUN); step_req = 1'b0; dwell = '0;
    rst2 = 1'b1; en2 = 1'b1; mode2 = 2'(SEQ_RUN); step2 = 1'b0; dwell2 = '0;
    test_reset();
    test_run_zero();
    test_dwell();
    test_step();
    test_hold();
    test_en_freeze();
    test_reset_mid();
    test_step_edges();
    test_cyc_rollover();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
